// File: rtl/rr_arb64_4_pkg.sv
// Shared widths, state encoding and helpers for the 4-way round-robin arbiter.
package rr_arb64_4_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam int DAT_W = 64;

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} arb_state_t;

  function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_arb64_4_mux.sv
// 64-bit 4:1 datapath mux driven by the arbiter select.
// Latency: combinational. Backpressure: none.
module mux64_4_2
  import rr_arb64_4_pkg::*;
(
  input  logic [DAT_W-1:0] d0,
  input  logic [DAT_W-1:0] d1,
  input  logic [DAT_W-1:0] d2,
  input  logic [DAT_W-1:0] d3,
  input  logic [SEL_W-1:0] x,
  output logic [DAT_W-1:0] y
);
  always_comb begin
    case (x)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

// File: rtl/rr_arb64_4_pick.sv
// Rotating-priority picker: first set request scanning ptr, ptr+1, ... mod 4.
// Latency: combinational. Backpressure: none, pure function of req/ptr.
module rr_pick4
  import rr_arb64_4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  // Scan from farthest to nearest so the nearest set request wins.
  always_comb begin
    idx = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) idx = ptr + SEL_W'(k);
    end
  end

  assign any = |req;
endmodule

// File: rtl/rr_arb64_4.sv
// Round-robin 4:1 arbiter with optional bursting and a one-entry registered output stage.
// Latency: 1 cycle in_valid&in_ready -> out_valid. Backpressure: out_ready low stalls all grants.
module rr_arb64_4
  import rr_arb64_4_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] in_valid,
  output logic [N_REQ-1:0] in_ready,
  input  logic [DAT_W-1:0] in_data0,
  input  logic [DAT_W-1:0] in_data1,
  input  logic [DAT_W-1:0] in_data2,
  input  logic [DAT_W-1:0] in_data3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DAT_W-1:0] out_data,
  output logic [SEL_W-1:0] out_src,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);
  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] owner;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] winner;
  logic [DAT_W-1:0] mux_dat;
  logic             any;
  logic             cnt_ok;
  logic             burst_hold;
  logic             slot_free;
  logic             fire;

  rr_pick4 u_pick (
    .req (in_valid),
    .ptr (ptr),
    .idx (pick_idx),
    .any (any)
  );

  mux64_4_2 u_mux (
    .d0 (in_data0),
    .d1 (in_data1),
    .d2 (in_data2),
    .d3 (in_data3),
    .x  (sel),
    .y  (mux_dat)
  );

  assign cnt_ok     = cnt < CNT_W'(MAX_BURST);
  assign burst_hold = (state == ST_BURST) && in_valid[owner] && cnt_ok;
  assign winner     = burst_hold ? owner : pick_idx;
  assign slot_free  = !out_valid || out_ready;
  // Gating with rst_n keeps the handshake silent while reset is asserted.
  assign fire       = rst_n && slot_free && any;
  assign in_ready   = fire ? onehot4(winner) : '0;
  assign sel        = !rst_n ? '0 : (any ? winner : owner);
  assign busy       = (state == ST_BURST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      state     <= ST_IDLE;
    end else if (fire) begin
      out_data  <= mux_dat;
      out_src   <= winner;
      out_valid <= 1'b1;
      if (winner == owner && state == ST_BURST && cnt_ok) begin
        cnt <= cnt + 1'b1;
      end else begin
        // New grant (or sole requester re-winning): owner rotates to lowest priority.
        owner <= winner;
        cnt   <= CNT_W'(1);
        ptr   <= winner + 1'b1;
        state <= ST_BURST;
      end
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (slot_free && !in_valid[owner]) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rr_arb64_4.sv
// Directed bench for rr_arb64_4: three instances (MAX_BURST 1, 4, 2) share stimulus.
module tb_rr_arb64_4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic        out_ready;
  logic [63:0] in_data0, in_data1, in_data2, in_data3;

  logic [3:0]  rdy_w  [3];
  logic [1:0]  sel_w  [3];
  logic [1:0]  src_w  [3];
  logic        ov_w   [3];
  logic        busy_w [3];
  logic [63:0] dat_w  [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_arb64_4 #(.MAX_BURST(1), .CNT_W(4)) u_mb1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[0]),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .out_valid(ov_w[0]), .out_ready(out_ready), .out_data(dat_w[0]), .out_src(src_w[0]),
    .sel(sel_w[0]), .busy(busy_w[0]));

  rr_arb64_4 #(.MAX_BURST(4), .CNT_W(4)) u_mb4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[1]),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .out_valid(ov_w[1]), .out_ready(out_ready), .out_data(dat_w[1]), .out_src(src_w[1]),
    .sel(sel_w[1]), .busy(busy_w[1]));

  rr_arb64_4 #(.MAX_BURST(2), .CNT_W(4)) u_mb2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[2]),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .out_valid(ov_w[2]), .out_ready(out_ready), .out_data(dat_w[2]), .out_src(src_w[2]),
    .sel(sel_w[2]), .busy(busy_w[2]));

  typedef struct {
    int          dut;
    logic        rst_n;
    logic [3:0]  iv;
    logic        ordy;
    logic [63:0] base;
    logic [3:0]  e_rdy;
    logic [1:0]  e_sel;
    logic        e_ov;
    logic [1:0]  e_src;
    logic [63:0] e_dat;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int dut, logic rst, logic [3:0] iv, logic ordy, logic [63:0] base,
                              logic [3:0] e_rdy, logic [1:0] e_sel, logic e_ov, logic [1:0] e_src,
                              logic [63:0] e_dat, logic e_busy);
    vec_t v;
    v.dut = dut; v.rst_n = rst; v.iv = iv; v.ordy = ordy; v.base = base;
    v.e_rdy = e_rdy; v.e_sel = e_sel; v.e_ov = e_ov; v.e_src = e_src;
    v.e_dat = e_dat; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] iv, input logic ordy, input logic [63:0] base);
    rst_n     = rst;
    in_valid  = iv;
    out_ready = ordy;
    in_data0  = base;
    in_data1  = base + 64'd1;
    in_data2  = base + 64'd2;
    in_data3  = base + 64'd3;
  endtask

  initial begin
    // Reset: all requesters valid, nothing may be accepted.
    vq.push_back(mk(1, 0, 4'hF, 1, 0,     4'h0, 0, 0, 0, 0,     0));
    vq.push_back(mk(1, 0, 4'hF, 1, 0,     4'h0, 0, 0, 0, 0,     0));
    // Pure round-robin (MAX_BURST=1).
    vq.push_back(mk(0, 1, 4'hF, 1, 0,     4'h1, 0, 1, 0, 0,     1));
    vq.push_back(mk(0, 1, 4'hF, 1, 0,     4'h2, 1, 1, 1, 1,     1));
    vq.push_back(mk(0, 1, 4'hF, 1, 0,     4'h4, 2, 1, 2, 2,     1));
    vq.push_back(mk(0, 1, 4'hF, 1, 0,     4'h8, 3, 1, 3, 3,     1));
    vq.push_back(mk(0, 1, 4'hF, 1, 0,     4'h1, 0, 1, 0, 0,     1));
    // Bursts of 4 (MAX_BURST=4), requester 1 drops after 2 beats.
    vq.push_back(mk(1, 0, 4'h0, 1, 0,     4'h0, 0, 0, 0, 0,     0));
    vq.push_back(mk(1, 1, 4'h3, 1, 0,     4'h1, 0, 1, 0, 0,     1));
    vq.push_back(mk(1, 1, 4'h3, 1, 0,     4'h1, 0, 1, 0, 0,     1));
    vq.push_back(mk(1, 1, 4'h3, 1, 0,     4'h1, 0, 1, 0, 0,     1));
    vq.push_back(mk(1, 1, 4'h3, 1, 0,     4'h1, 0, 1, 0, 0,     1));
    vq.push_back(mk(1, 1, 4'h3, 1, 0,     4'h2, 1, 1, 1, 1,     1));
    vq.push_back(mk(1, 1, 4'h3, 1, 0,     4'h2, 1, 1, 1, 1,     1));
    vq.push_back(mk(1, 1, 4'h1, 1, 0,     4'h1, 0, 1, 0, 0,     1));
    // Backpressure for 3 cycles holding 64'hA5, then the burst resumes.
    vq.push_back(mk(1, 1, 4'h3, 1, 'hA5,  4'h1, 0, 1, 0, 'hA5,  1));
    vq.push_back(mk(1, 1, 4'h3, 0, 'hA5,  4'h0, 0, 1, 0, 'hA5,  1));
    vq.push_back(mk(1, 1, 4'h3, 0, 'hA5,  4'h0, 0, 1, 0, 'hA5,  1));
    vq.push_back(mk(1, 1, 4'h3, 0, 'hA5,  4'h0, 0, 1, 0, 'hA5,  1));
    vq.push_back(mk(1, 1, 4'h3, 1, 'hA5,  4'h1, 0, 1, 0, 'hA5,  1));
    vq.push_back(mk(1, 1, 4'h3, 1, 'hA5,  4'h1, 0, 1, 0, 'hA5,  1));
    vq.push_back(mk(1, 1, 4'h3, 1, 'hA5,  4'h2, 1, 1, 1, 'hA6,  1));
    // Sole requester 3 with MAX_BURST=2, then requester 0 joins.
    vq.push_back(mk(2, 0, 4'h0, 1, 0,     4'h0, 0, 0, 0, 0,     0));
    vq.push_back(mk(2, 1, 4'h8, 1, 0,     4'h8, 3, 1, 3, 3,     1));
    vq.push_back(mk(2, 1, 4'h8, 1, 0,     4'h8, 3, 1, 3, 3,     1));
    vq.push_back(mk(2, 1, 4'h8, 1, 0,     4'h8, 3, 1, 3, 3,     1));
    vq.push_back(mk(2, 1, 4'h8, 1, 0,     4'h8, 3, 1, 3, 3,     1));
    vq.push_back(mk(2, 1, 4'h9, 1, 0,     4'h1, 0, 1, 0, 0,     1));
    // Reset mid-burst, then a fresh pointer; finally idle with sel holding owner.
    vq.push_back(mk(1, 0, 4'h0, 1, 0,     4'h0, 0, 0, 0, 0,     0));
    vq.push_back(mk(1, 1, 4'h2, 1, 0,     4'h2, 1, 1, 1, 1,     1));
    vq.push_back(mk(1, 1, 4'h2, 1, 0,     4'h2, 1, 1, 1, 1,     1));
    vq.push_back(mk(1, 0, 4'h3, 1, 0,     4'h0, 0, 0, 0, 0,     0));
    vq.push_back(mk(1, 1, 4'hB, 1, 0,     4'h1, 0, 1, 0, 0,     1));
    vq.push_back(mk(1, 1, 4'h4, 1, 0,     4'h4, 2, 1, 2, 2,     1));
    vq.push_back(mk(1, 1, 4'h0, 1, 0,     4'h0, 2, 0, 2, 2,     0));

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      drive(v.rst_n, v.iv, v.ordy, v.base);
      #1;
      chk($sformatf("v%0d.in_ready", i), 64'(rdy_w[v.dut]), 64'(v.e_rdy));
      chk($sformatf("v%0d.sel", i), 64'(sel_w[v.dut]), 64'(v.e_sel));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.out_valid", i), 64'(ov_w[v.dut]), 64'(v.e_ov));
      chk($sformatf("v%0d.out_src", i), 64'(src_w[v.dut]), 64'(v.e_src));
      chk($sformatf("v%0d.out_data", i), dat_w[v.dut], v.e_dat);
      chk($sformatf("v%0d.busy", i), 64'(busy_w[v.dut]), 64'(v.e_busy));
    end

    // Full-rate streaming, MAX_BURST=4: four beats per requester, one word per cycle.
    drive(0, 4'h0, 1, 64'h100);
    @(posedge clk);
    #1;
    for (int k = 0; k < 12; k++) begin
      logic [1:0] es;
      es = 2'(k / 4);
      drive(1, 4'hF, 1, 64'h100);
      #1;
      chk($sformatf("s%0d.in_ready", k), 64'(rdy_w[1]), 64'(4'b0001 << es));
      @(posedge clk);
      #1;
      chk($sformatf("s%0d.out_valid", k), 64'(ov_w[1]), 64'd1);
      chk($sformatf("s%0d.out_src", k), 64'(src_w[1]), 64'(es));
      chk($sformatf("s%0d.out_data", k), dat_w[1], 64'h100 + 64'(es));
    end
    drive(1, 4'h0, 1, 64'h100);
    @(posedge clk);
    #1;
    chk("drain.out_valid", 64'(ov_w[1]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
